// File: rtl/sr_flag_arbiter_if.sv
// rtl/sr_flag_arbiter_if.sv - requester command bus for sr_flag_arbiter
interface sr_flag_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*IDX_W-1:0] req_idx;
  logic [NUM_REQ*2-1:0]     req_op;

  modport master (output req_valid, output req_idx, output req_op, input req_ready);
  modport slave  (input req_valid, input req_idx, input req_op, output req_ready);
endinterface

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin arbitrated bank of set/reset status flags
module sr_flag_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int NUM_FLAGS       = 8,
  parameter int IDX_W           = 3,
  parameter int CONFLICT_POLICY = 0,
  parameter int CNT_W           = 8,
  localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sr_flag_arbiter_if.slave     req,
  input  logic                 clr_all,
  output logic [NUM_FLAGS-1:0] flags,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     conflict_cnt
);
  localparam logic [1:0] OP_NOP      = 2'b00;
  localparam logic [1:0] OP_CLR      = 2'b01;
  localparam logic [1:0] OP_SET      = 2'b10;
  localparam logic [1:0] OP_CONFLICT = 2'b11;

  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      cand_id;
  logic                 found;
  logic                 hs;
  logic                 in_range;
  logic                 is_conflict;
  logic [IDX_W-1:0]     sel_idx;
  logic [1:0]           sel_op;
  logic [NUM_FLAGS-1:0] flags_nxt;
  int                   cand;

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    cand    = 0;
    cand_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_id = ID_W'(cand);
      if (!found && req.req_valid[cand_id]) begin
        found  = 1'b1;
        winner = cand_id;
      end
    end
  end

  always_comb begin
    req.req_ready = '0;
    if (found && !clr_all && rst_n) req.req_ready[winner] = 1'b1;
  end

  assign hs          = |(req.req_valid & req.req_ready);
  assign sel_idx     = req.req_idx[int'(winner)*IDX_W +: IDX_W];
  assign sel_op      = req.req_op[int'(winner)*2 +: 2];
  assign in_range    = int'(sel_idx) < NUM_FLAGS;
  assign is_conflict = (sel_op == OP_CONFLICT);

  always_comb begin
    flags_nxt = flags;
    for (int f = 0; f < NUM_FLAGS; f++) begin
      if (in_range && int'(sel_idx) == f) begin
        case (sel_op)
          OP_NOP: ;
          OP_CLR: flags_nxt[f] = 1'b0;
          OP_SET: flags_nxt[f] = 1'b1;
          OP_CONFLICT: begin
            // Policy 0 holds the current value, so only 1 and 2 modify it.
            if (CONFLICT_POLICY == 1)      flags_nxt[f] = 1'b1;
            else if (CONFLICT_POLICY == 2) flags_nxt[f] = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags        <= '0;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      err_pulse    <= 1'b0;
      conflict_cnt <= '0;
      ptr          <= '0;
    end else if (clr_all) begin
      flags       <= '0;
      grant_valid <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      grant_valid <= hs;
      err_pulse   <= hs && (is_conflict || !in_range);
      if (hs) begin
        ptr      <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        grant_id <= winner;
        flags    <= flags_nxt;
        if (is_conflict && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - scoreboard bench for sr_flag_arbiter across three policy builds
module tb_sr_flag_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  vld = '0;
  logic [11:0] idx = '0;
  logic [7:0]  op = '0;
  int          total = 0;
  int          bad = 0;

  typedef struct {logic [1:0] id; logic err;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  sr_flag_arbiter_if #(.NUM_REQ(4), .IDX_W(3)) if_a(), if_b(), if_c();
  assign if_a.req_valid = vld;  assign if_a.req_idx = idx;  assign if_a.req_op = op;
  assign if_b.req_valid = vld;  assign if_b.req_idx = idx;  assign if_b.req_op = op;
  assign if_c.req_valid = vld;  assign if_c.req_idx = idx;  assign if_c.req_op = op;

  logic [7:0] fa, fc, cnt_a, cnt_c;
  logic [5:0] fb;
  logic [1:0] cnt_b, gid_a, gid_b, gid_c;
  logic       gv_a, gv_b, gv_c, err_a, err_b, err_c;

  sr_flag_arbiter #(.CONFLICT_POLICY(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(if_a.slave), .clr_all(clr), .flags(fa),
    .grant_valid(gv_a), .grant_id(gid_a), .err_pulse(err_a), .conflict_cnt(cnt_a));
  sr_flag_arbiter #(.NUM_FLAGS(6), .CONFLICT_POLICY(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(if_b.slave), .clr_all(clr), .flags(fb),
    .grant_valid(gv_b), .grant_id(gid_b), .err_pulse(err_b), .conflict_cnt(cnt_b));
  sr_flag_arbiter #(.CONFLICT_POLICY(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(if_c.slave), .clr_all(clr), .flags(fc),
    .grant_valid(gv_c), .grant_id(gid_c), .err_pulse(err_c), .conflict_cnt(cnt_c));

  task automatic set_req(input int r, input logic [2:0] i, input logic [1:0] o);
    idx[r*3 +: 3] = i;
    op[r*2 +: 2]  = o;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; vld = '0; clr = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    vld = 4'hF;
    @(negedge clk);
    total++; if ({fa, gv_a, gid_a, err_a, cnt_a} !== 20'h0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {fa, gv_a, gid_a, err_a, cnt_a}); end
    total++; if (if_a.req_ready !== 4'h0) begin
      bad++; $display("FAIL reset_ready got=%b exp=0000", if_a.req_ready); end
    vld = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_req(2, 3'd5, 2'b10);
    vld = 4'b0100;
    #1;
    total++; if (if_a.req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready got=%b exp=0100", if_a.req_ready); end
    exp_q.push_back('{id: 2'd2, err: 1'b0});
    @(posedge clk); @(negedge clk);
    vld = '0;
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL single_sb got=empty exp=entry"); end
    else begin
      e = exp_q.pop_front();
      if ({gv_a, gid_a, err_a} !== {1'b1, e.id, e.err}) begin
        bad++; $display("FAIL single_grant got=%b exp=%b", {gv_a, gid_a, err_a}, {1'b1, e.id, e.err}); end
    end
    total++; if (fa !== 8'h20) begin bad++; $display("FAIL single_flags got=%h exp=20", fa); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int r = 0; r < 4; r++) set_req(r, 3'(r), 2'b10);
    vld = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      total++; if (if_a.req_ready !== (4'b0001 << (c % 4))) begin
        bad++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, if_a.req_ready, 4'b0001 << (c % 4)); end
      exp_q.push_back('{id: 2'(c % 4), err: 1'b0});
      @(posedge clk); @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL rr_sb got=empty exp=entry"); end
      else begin
        e = exp_q.pop_front();
        if ({gv_a, gid_a, err_a} !== {1'b1, e.id, e.err}) begin
          bad++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, {gv_a, gid_a, err_a}, {1'b1, e.id, e.err}); end
      end
    end
    vld = '0;
    total++; if (fa !== 8'h0F) begin bad++; $display("FAIL rr_flags got=%h exp=0f", fa); end
  endtask

  task automatic test_conflict();
    set_req(1, 3'd3, 2'b11);
    vld = 4'b0010;
    #1;
    total++; if (if_a.req_ready !== 4'b0010) begin
      bad++; $display("FAIL conf_ready got=%b exp=0010", if_a.req_ready); end
    exp_q.push_back('{id: 2'd1, err: 1'b1});
    @(posedge clk); @(negedge clk);
    vld = '0;
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL conf_sb got=empty exp=entry"); end
    else begin
      e = exp_q.pop_front();
      if ({gv_a, gid_a, err_a} !== {1'b1, e.id, e.err}) begin
        bad++; $display("FAIL conf_grant got=%b exp=%b", {gv_a, gid_a, err_a}, {1'b1, e.id, e.err}); end
    end
    total++; if ({fa[3], fb[3], fc[3]} !== 3'b110) begin
      bad++; $display("FAIL conf_policy_flag3 got=%b exp=110", {fa[3], fb[3], fc[3]}); end
    total++; if ({err_b, err_c} !== 2'b11) begin
      bad++; $display("FAIL conf_err_bc got=%b exp=11", {err_b, err_c}); end
    total++; if ({cnt_a, cnt_b, cnt_c} !== {8'd1, 2'd1, 8'd1}) begin
      bad++; $display("FAIL conf_cnt got=%h exp=%h", {cnt_a, cnt_b, cnt_c}, {8'd1, 2'd1, 8'd1}); end
    @(negedge clk);
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL conf_pulse_end got=%b exp=0", err_a); end
  endtask

  task automatic test_back_to_back();
    set_req(0, 3'd4, 2'b11);
    vld = 4'b0001;
    for (int n = 0; n < 5; n++) begin
      exp_q.push_back('{id: 2'd0, err: 1'b1});
      @(posedge clk); @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_sb got=empty exp=entry"); end
      else begin
        e = exp_q.pop_front();
        if ({gv_a, gid_a, err_a, err_b} !== {1'b1, e.id, e.err, 1'b1}) begin
          bad++; $display("FAIL b2b_grant n=%0d got=%b exp=%b", n, {gv_a, gid_a, err_a, err_b}, {1'b1, e.id, e.err, 1'b1}); end
      end
    end
    vld = '0;
    total++; if (cnt_b !== 2'd3) begin bad++; $display("FAIL b2b_sat got=%0d exp=3", cnt_b); end
    total++; if (cnt_a !== 8'd6) begin bad++; $display("FAIL b2b_cnt got=%0d exp=6", cnt_a); end
    total++; if ({fa[4], fb[4], fc[4]} !== 3'b010) begin
      bad++; $display("FAIL b2b_policy_flag4 got=%b exp=010", {fa[4], fb[4], fc[4]}); end
    @(negedge clk);
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL b2b_pulse_end got=%b exp=0", err_a); end
  endtask

  task automatic test_out_of_range();
    set_req(3, 3'd7, 2'b10);
    vld = 4'b1000;
    @(posedge clk); @(negedge clk);
    vld = '0;
    total++; if ({fb, err_b} !== {6'h1F, 1'b1}) begin
      bad++; $display("FAIL oor_b got=%h exp=%h", {fb, err_b}, {6'h1F, 1'b1}); end
    total++; if ({fa, err_a} !== {8'h8F, 1'b0}) begin
      bad++; $display("FAIL oor_a got=%h exp=%h", {fa, err_a}, {8'h8F, 1'b0}); end
    @(negedge clk);
    total++; if ({fb, err_b} !== {6'h1F, 1'b0}) begin
      bad++; $display("FAIL oor_pulse_end got=%h exp=%h", {fb, err_b}, {6'h1F, 1'b0}); end
  endtask

  task automatic test_clr_all();
    for (int i = 4; i < 7; i++) begin
      set_req(0, 3'(i), 2'b10);
      vld = 4'b0001;
      @(posedge clk); @(negedge clk);
    end
    vld = '0;
    total++; if (fa !== 8'hFF) begin bad++; $display("FAIL clr_fill got=%h exp=ff", fa); end
    set_req(0, 3'd0, 2'b10);
    vld = 4'b0001;
    clr = 1'b1;
    #1;
    total++; if (if_a.req_ready !== 4'b0000) begin
      bad++; $display("FAIL clr_ready got=%b exp=0000", if_a.req_ready); end
    @(posedge clk); @(negedge clk);
    total++; if ({fa, gv_a, cnt_a} !== {8'h00, 1'b0, 8'd6}) begin
      bad++; $display("FAIL clr_effect got=%h exp=%h", {fa, gv_a, cnt_a}, {8'h00, 1'b0, 8'd6}); end
    clr = 1'b0;
    #1;
    total++; if (if_a.req_ready !== 4'b0001) begin
      bad++; $display("FAIL clr_after_ready got=%b exp=0001", if_a.req_ready); end
    @(posedge clk); @(negedge clk);
    vld = '0;
    total++; if ({fa, gv_a, gid_a} !== {8'h01, 1'b1, 2'd0}) begin
      bad++; $display("FAIL clr_after_grant got=%h exp=%h", {fa, gv_a, gid_a}, {8'h01, 1'b1, 2'd0}); end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 4; r++) set_req(r, 3'd0, 2'b00);
    vld = 4'hF;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({fa, gv_a, gid_a, err_a, cnt_a} !== 20'h0) begin
      bad++; $display("FAIL rstmid_outputs got=%h exp=0", {fa, gv_a, gid_a, err_a, cnt_a}); end
    total++; if (if_a.req_ready !== 4'b0000) begin
      bad++; $display("FAIL rstmid_ready got=%b exp=0000", if_a.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (if_a.req_ready !== 4'b0001) begin
      bad++; $display("FAIL rstmid_first_ready got=%b exp=0001", if_a.req_ready); end
    @(posedge clk); @(negedge clk);
    vld = '0;
    total++; if ({gv_a, gid_a} !== {1'b1, 2'd0}) begin
      bad++; $display("FAIL rstmid_first_grant got=%b exp=100", {gv_a, gid_a}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_conflict();
    test_back_to_back();
    test_out_of_range();
    test_clr_all();
    test_reset_mid();
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
